// File: rtl/apb_chk_pkg.sv
// Shared types and constants for the APB protocol checker.
package apb_chk_pkg;

  // Transfer phase as seen on the previous pclock edge
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int NUM_ERR = 5;

  localparam int E_SEL_MULTI       = 0;
  localparam int E_ENABLE_NO_SETUP = 1;
  localparam int E_UNSTABLE        = 2;
  localparam int E_ENABLE_MISSING  = 3;
  localparam int E_TIMEOUT         = 4;

  // Index of the lowest set error bit; used when several errors hit on one edge
  function automatic logic [2:0] lowest_err(input logic [NUM_ERR-1:0] errs);
    logic [2:0] code;
    code = 3'd0;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (errs[i]) code = 3'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/apb_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear, used for transfer statistics.
module apb_chk_sat_cnt
  import apb_chk_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             pclock,
  input  logic             preset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  // Clear takes effect before a same-edge increment, so that event is still counted
  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? WIDTH'(1) : '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB protocol checker: tracks the transfer phase, raises sticky
// maskable violation flags, captures the first violation and counts transfers.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no transfer in progress; waiting for a setup phase
// SETUP  | previous edge saw a setup; this edge must be the first access
// ACCESS | in wait states; wait_cnt holds the number of wait cycles so far
module apb_protocol_checker
  import apb_chk_pkg::*;
#(
  parameter int PADDR_WIDTH    = 32,
  parameter int PWDATA_WIDTH   = 32,
  parameter int NUM_SLAVES     = 16,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    pclock,
  input  logic                    preset,
  input  logic                    chk_en,
  input  logic                    clr,
  input  logic [NUM_SLAVES-1:0]   psel,
  input  logic                    penable,
  input  logic                    prwd,
  input  logic [PADDR_WIDTH-1:0]  paddr,
  input  logic [PWDATA_WIDTH-1:0] pwdata,
  input  logic                    pready,
  input  logic                    pslverr,
  input  logic [NUM_ERR-1:0]      err_mask,
  output logic [NUM_ERR-1:0]      err_flags,
  output logic                    err_irq,
  output logic                    first_err_valid,
  output logic [2:0]              first_err_code,
  output logic [PADDR_WIDTH-1:0]  first_err_addr,
  output logic [CNT_WIDTH-1:0]    xfer_cnt,
  output logic [CNT_WIDTH-1:0]    slverr_cnt
);

  // Wide enough to hold TIMEOUT_CYCLES itself
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [WAIT_W-1:0]       wait_nxt;
  logic [NUM_SLAVES-1:0]   cap_psel;
  logic [PADDR_WIDTH-1:0]  cap_paddr;
  logic                    cap_prwd;
  logic [PWDATA_WIDTH-1:0] cap_pwdata;
  logic                    load_cap;
  logic                    complete;
  logic                    sel_multi;
  logic                    unstable;
  logic [NUM_ERR-1:0]      err_set;
  logic [NUM_ERR-1:0]      err_hit;
  logic                    first_load;

  // More than one select bit: clearing the lowest set bit leaves something behind
  generate
    if (NUM_SLAVES > 1) begin : g_sel_multi
      assign sel_multi = |(psel & (psel - NUM_SLAVES'(1)));
    end else begin : g_sel_single
      assign sel_multi = 1'b0;
    end
  endgenerate

  // Any control or address change against the setup capture; write data only matters on writes
  assign unstable = (psel != cap_psel) || (paddr != cap_paddr) || (prwd != cap_prwd) ||
                    (cap_prwd && (pwdata != cap_pwdata));

  // Phase tracking and rule evaluation for the current edge
  always_comb begin
    state_nxt              = state;
    wait_nxt               = wait_cnt;
    load_cap               = 1'b0;
    complete               = 1'b0;
    err_set                = '0;
    err_set[E_SEL_MULTI]   = sel_multi;
    case (state)
      IDLE: begin
        if (penable) begin
          err_set[E_ENABLE_NO_SETUP] = 1'b1;
        end else if (|psel) begin
          load_cap  = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP, ACCESS: begin
        err_set[E_UNSTABLE] = unstable;
        if (!penable) begin
          err_set[E_ENABLE_MISSING] = 1'b1;
          state_nxt                 = IDLE;
          wait_nxt                  = '0;
        end else if (pready) begin
          complete  = 1'b1;
          state_nxt = IDLE;
          wait_nxt  = '0;
        end else if (state == SETUP) begin
          state_nxt = ACCESS;
          wait_nxt  = WAIT_W'(1);
        end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES)) begin
          // Transfer is abandoned; a late pready is treated as idle-bus activity
          err_set[E_TIMEOUT] = 1'b1;
          state_nxt          = IDLE;
          wait_nxt           = '0;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        wait_nxt  = '0;
      end
    endcase
  end

  assign err_hit    = chk_en ? err_set : '0;
  assign first_load = (|err_hit) && (clr || !first_err_valid);

  // Phase state, wait counter and setup-phase capture
  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      cap_psel   <= '0;
      cap_paddr  <= '0;
      cap_prwd   <= 1'b0;
      cap_pwdata <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (load_cap) begin
        cap_psel   <= psel;
        cap_paddr  <= paddr;
        cap_prwd   <= prwd;
        cap_pwdata <= pwdata;
      end
    end
  end

  // Sticky flags and interrupt; clr wipes old flags but a same-edge error still lands
  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) begin
      err_flags <= '0;
      err_irq   <= 1'b0;
    end else begin
      err_flags <= (clr ? '0 : err_flags) | err_hit;
      err_irq   <= |(err_flags & err_mask);
    end
  end

  // First-error capture, reopened by clr
  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) begin
      first_err_valid <= 1'b0;
      first_err_code  <= 3'd0;
      first_err_addr  <= '0;
    end else if (first_load) begin
      first_err_valid <= 1'b1;
      first_err_code  <= lowest_err(err_hit);
      first_err_addr  <= paddr;
    end else if (clr) begin
      first_err_valid <= 1'b0;
      first_err_code  <= 3'd0;
      first_err_addr  <= '0;
    end
  end

  apb_chk_sat_cnt #(.WIDTH(CNT_WIDTH)) u_xfer_cnt (
    .pclock (pclock),
    .preset (preset),
    .inc    (complete),
    .clr    (clr),
    .cnt    (xfer_cnt)
  );

  apb_chk_sat_cnt #(.WIDTH(CNT_WIDTH)) u_slverr_cnt (
    .pclock (pclock),
    .preset (preset),
    .inc    (complete & pslverr),
    .clr    (clr),
    .cnt    (slverr_cnt)
  );

endmodule
